// File: rtl/rmii_rx_mac.sv
// RMII receive framer: hunts preamble/SFD, packs dibits into bytes and reports
// each frame as a byte stream with sof/eof markers, length and FCS status.
module rmii_rx_mac #(
    parameter int PREAMBLE_MIN = 4,
    parameter int MAX_LEN      = 1522
) (
    input  logic        clk_50_mhz,
    input  logic        rst_n,
    input  logic        crs_dv,
    input  logic [1:0]  rx_d,
    input  logic        rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic        fcs_ok,
    output logic [10:0] frame_len
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    state_t      r_state;
    logic [3:0]  r_pcnt;
    logic [1:0]  r_phase;
    logic [5:0]  r_sh;
    logic [7:0]  r_hold;
    logic [10:0] r_cnt;
    logic [31:0] r_crc;
    logic        r_er;
    logic        r_sof_pend;
    logic        r_dv_d;

    logic        w_cend;
    logic [7:0]  w_byte;
    logic [31:0] w_crc_nx;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Two low samples in a row end the carrier; a lone low sample is a stall.
    assign w_cend   = !crs_dv && !r_dv_d;
    assign w_byte   = {rx_d, r_sh};
    assign w_crc_nx = crc_byte(r_crc, w_byte);

    always_ff @(posedge clk_50_mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pcnt     <= '0;
            r_phase    <= '0;
            r_sh       <= '0;
            r_hold     <= '0;
            r_cnt      <= '0;
            r_crc      <= CRC_INIT;
            r_er       <= 1'b0;
            r_sof_pend <= 1'b0;
            r_dv_d     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_eof     <= 1'b0;
            rx_err     <= 1'b0;
            fcs_ok     <= 1'b0;
            frame_len  <= '0;
        end else begin
            r_dv_d   <= crs_dv;
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_err   <= 1'b0;
            fcs_ok   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (crs_dv && rx_d == 2'b01) begin
                        r_state <= S_PRE;
                        r_pcnt  <= 4'd1;
                    end
                end
                S_PRE: begin
                    if (w_cend) begin
                        r_state <= S_IDLE;
                    end else if (crs_dv) begin
                        case (rx_d)
                            2'b01: if (r_pcnt != 4'd15) r_pcnt <= r_pcnt + 4'd1;
                            2'b11: begin
                                if (r_pcnt >= 4'(PREAMBLE_MIN)) begin
                                    r_state    <= S_DATA;
                                    r_phase    <= '0;
                                    r_cnt      <= '0;
                                    r_crc      <= CRC_INIT;
                                    r_er       <= 1'b0;
                                    r_sof_pend <= 1'b1;
                                end else begin
                                    r_state <= S_DROP;
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_DATA: begin
                    if (w_cend) begin
                        if (r_cnt != '0) begin
                            rx_valid  <= 1'b1;
                            rx_data   <= r_hold;
                            rx_sof    <= r_sof_pend;
                            rx_eof    <= 1'b1;
                            rx_err    <= r_er | (r_phase != 2'd0);
                            fcs_ok    <= (r_crc == CRC_RESIDUE);
                            frame_len <= r_cnt;
                        end
                        r_state <= S_IDLE;
                    end else if (crs_dv) begin
                        r_er    <= r_er | rx_er;
                        r_sh    <= w_byte[7:2];
                        r_phase <= r_phase + 2'd1;
                        if (r_phase == 2'd3) begin
                            if (r_cnt == 11'(MAX_LEN)) begin
                                // Byte MAX_LEN+1 is dropped; close out with what we hold.
                                rx_valid  <= 1'b1;
                                rx_data   <= r_hold;
                                rx_sof    <= r_sof_pend;
                                rx_eof    <= 1'b1;
                                rx_err    <= 1'b1;
                                fcs_ok    <= (r_crc == CRC_RESIDUE);
                                frame_len <= r_cnt;
                                r_state   <= S_DROP;
                            end else begin
                                if (r_cnt != '0) begin
                                    rx_valid   <= 1'b1;
                                    rx_data    <= r_hold;
                                    rx_sof     <= r_sof_pend;
                                    r_sof_pend <= 1'b0;
                                end
                                r_hold <= w_byte;
                                r_cnt  <= r_cnt + 11'd1;
                                r_crc  <= w_crc_nx;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (w_cend) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx_mac.sv
// Directed bench for rmii_rx_mac: frames are driven dibit by dibit, expected
// strobes are queued up front and matched as the receiver emits them.
module tb_rmii_rx_mac;

    logic        clk_50_mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        crs_dv = 1'b0;
    logic [1:0]  rx_d = 2'b00;
    logic        rx_er = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_err, fcs_ok;
    logic [10:0] frame_len;

    rmii_rx_mac dut (
        .clk_50_mhz(clk_50_mhz), .rst_n(rst_n), .crs_dv(crs_dv), .rx_d(rx_d),
        .rx_er(rx_er), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_eof(rx_eof), .rx_err(rx_err), .fcs_ok(fcs_ok), .frame_len(frame_len)
    );

    always #10 clk_50_mhz = ~clk_50_mhz;

    typedef struct {
        logic [7:0]  d;
        logic        sof, eof, err, fcs;
        logic [10:0] len;
    } exp_t;

    exp_t       q[$];
    int         checks = 0, errors = 0, nstrobe = 0, n0;
    logic       prev_v = 1'b0;
    logic [7:0] fr[0:1599];
    int         fr_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_50_mhz) begin
        exp_t e;
        if (rx_valid) begin
            nstrobe++;
            chk("strobe_gap", {31'd0, prev_v}, 32'd0);
            chk("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("data", {24'd0, rx_data}, {24'd0, e.d});
                chk("sof", {31'd0, rx_sof}, {31'd0, e.sof});
                chk("eof", {31'd0, rx_eof}, {31'd0, e.eof});
                if (e.eof) begin
                    chk("err", {31'd0, rx_err}, {31'd0, e.err});
                    chk("fcs_ok", {31'd0, fcs_ok}, {31'd0, e.fcs});
                    chk("frame_len", {21'd0, frame_len}, {21'd0, e.len});
                end
            end
        end
        prev_v = rx_valid;
    end

    task automatic dibit(input logic [1:0] d, input logic er);
        @(posedge clk_50_mhz); #2;
        crs_dv = 1'b1; rx_d = d; rx_er = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50_mhz); #2;
            crs_dv = 1'b0; rx_d = 2'b00; rx_er = 1'b0;
        end
    endtask

    task automatic load_check();
        logic [7:0] b[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                              8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 13; i++) fr[i] = b[i];
        fr_n = 13;
    endtask

    task automatic push_frame(input logic err, input logic fcs);
        exp_t e;
        for (int i = 0; i < fr_n; i++) begin
            e.d = fr[i]; e.sof = (i == 0); e.eof = (i == fr_n - 1);
            e.err = err; e.fcs = fcs; e.len = 11'(fr_n);
            q.push_back(e);
        end
    endtask

    // stall_at / er_at are dibit indices within the payload (-1 = none).
    task automatic send_frame(input int npre, input int stall_at, input int er_at, input int extra);
        for (int i = 0; i < npre; i++) dibit(2'b01, 1'b0);
        dibit(2'b11, 1'b0);
        for (int i = 0; i < fr_n; i++)
            for (int k = 0; k < 4; k++) begin
                if (i * 4 + k == stall_at) idle(1);
                dibit(2'((fr[i] >> (2 * k)) & 8'h3), (i * 4 + k) == er_at);
            end
        for (int i = 0; i < extra; i++) dibit(2'b10, 1'b0);
        idle(8);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"}, {24'd0, rx_data}, 32'd0);
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_sof"}, {31'd0, rx_sof}, 32'd0);
        chk({tag, "_eof"}, {31'd0, rx_eof}, 32'd0);
        chk({tag, "_err"}, {31'd0, rx_err}, 32'd0);
        chk({tag, "_fcs"}, {31'd0, fcs_ok}, 32'd0);
        chk({tag, "_len"}, {21'd0, frame_len}, 32'd0);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk_50_mhz);
        #2;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        idle(3);

        // Clean "123456789" frame with correct FCS.
        load_check(); push_frame(1'b0, 1'b1);
        n0 = nstrobe; send_frame(7, -1, -1, 0);
        chk("f1_strobes", nstrobe - n0, 32'd13);
        chk("f1_len_held", {21'd0, frame_len}, 32'd13);

        // Corrupted FCS.
        load_check(); for (int i = 9; i < 13; i++) fr[i] = 8'h00;
        push_frame(1'b0, 1'b0); send_frame(7, -1, -1, 0);

        // Short preamble: whole frame dropped, next frame received.
        for (int i = 0; i < 8; i++) fr[i] = 8'(8'h5A + i);
        fr_n = 8; n0 = nstrobe; send_frame(3, -1, -1, 0);
        chk("short_pre_strobes", nstrobe - n0, 32'd0);
        load_check(); push_frame(1'b0, 1'b1); send_frame(7, -1, -1, 0);

        // Stall mid byte 5, rx_er pulse in byte 7.
        load_check(); push_frame(1'b1, 1'b1);
        n0 = nstrobe; send_frame(7, 4 * 4 + 2, 6 * 4 + 1, 0);
        chk("f4_strobes", nstrobe - n0, 32'd13);

        // Two bytes plus three stray dibits: alignment error.
        fr[0] = 8'h55; fr[1] = 8'hAA; fr_n = 2;
        push_frame(1'b1, 1'b0); n0 = nstrobe; send_frame(7, -1, -1, 3);
        chk("align_strobes", nstrobe - n0, 32'd2);

        // Single-byte frame: sof and eof on the same strobe.
        fr[0] = 8'hA5; fr_n = 1;
        push_frame(1'b0, 1'b0); send_frame(5, -1, -1, 0);

        // Overlength: 1525 bytes sent, 1522 reported with error.
        fr_n = 1525;
        for (int i = 0; i < fr_n; i++) fr[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 1522; i++) begin
            e.d = fr[i]; e.sof = (i == 0); e.eof = (i == 1521);
            e.err = 1'b1; e.fcs = 1'b0; e.len = 11'd1522;
            q.push_back(e);
        end
        n0 = nstrobe; send_frame(7, -1, -1, 0);
        chk("ovl_strobes", nstrobe - n0, 32'd1522);

        // Reset after four bytes: bytes 1..3 already out, no eof afterwards.
        load_check();
        for (int i = 0; i < 3; i++) begin
            e.d = fr[i]; e.sof = (i == 0); e.eof = 1'b0;
            e.err = 1'b0; e.fcs = 1'b0; e.len = 11'd0;
            q.push_back(e);
        end
        n0 = nstrobe;
        for (int i = 0; i < 7; i++) dibit(2'b01, 1'b0);
        dibit(2'b11, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) dibit(2'((fr[i] >> (2 * k)) & 8'h3), 1'b0);
        dibit(2'(fr[4] & 8'h3), 1'b0);
        @(posedge clk_50_mhz); #2;
        rst_n = 1'b0; crs_dv = 1'b0; rx_d = 2'b00;
        #1;
        chk_outputs_zero("midrst");
        chk("midrst_strobes", nstrobe - n0, 32'd3);
        idle(3);
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_strobes", nstrobe - n0, 32'd3);
        load_check(); push_frame(1'b0, 1'b1); send_frame(7, -1, -1, 0);
        chk("post_rst_len", {21'd0, frame_len}, 32'd13);

        idle(10);
        chk("sb_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
